register_pipe: RTL and testbench

//   Parametrised multi-stage pipeline register with valid/ready handshake.

---
 rtl/register_pkg.sv | 29 ++
 rtl/register_pipe_if.sv | 41 ++++
 rtl/register_stage.sv | 41 ++++
 rtl/register_pipe.sv | 97 +++++++++
 tb/tb_register_pipe.sv | 192 +++++++++++++++++++
 5 files changed

// File: rtl/register_pkg.sv
// Shared helpers for the register pipe: occupancy width, stage record type
// and the transfer classification used by the occupancy counter.
`ifndef REGISTER_PKG_SV
`define REGISTER_PKG_SV

// Stage record {valid, data}; W is the data width in bits.
`define REGISTER_STAGE_REC(W) struct packed { logic valid; logic [(W)-1:0] data; }

package register_pkg;

    localparam int DEFAULT_NB_BITS   = 32;
    localparam int DEFAULT_NB_STAGES = 3;

    // Bits needed to count 0..n valid stages.
    function automatic int occ_width(input int n);
        return $clog2(n + 1);
    endfunction

    // Encoded as {input accept, output transfer}.
    typedef enum logic [1:0] {
        XFER_NONE = 2'b00,
        XFER_OUT  = 2'b01,
        XFER_IN   = 2'b10,
        XFER_BOTH = 2'b11
    } xfer_e;

endpackage

`endif

// File: rtl/register_pipe_if.sv
// Producer/consumer handshake bundle of the register pipe; master drives the
// pipe inputs, slave is the pipe itself.
interface register_pipe_if #(
    parameter int nb_bits   = 32,
    parameter int nb_stages = 3
) ();

    localparam int OCC_W = register_pkg::occ_width(nb_stages);

    logic [nb_bits-1:0] data_i;
    logic               valid_i;
    logic               ready_o;
    logic               flush_i;
    logic [nb_bits-1:0] data_o;
    logic               valid_o;
    logic               ready_i;
    logic [OCC_W-1:0]   occupancy_o;

    modport master (
        output data_i,
        output valid_i,
        output flush_i,
        output ready_i,
        input  ready_o,
        input  data_o,
        input  valid_o,
        input  occupancy_o
    );

    modport slave (
        input  data_i,
        input  valid_i,
        input  flush_i,
        input  ready_i,
        output ready_o,
        output data_o,
        output valid_o,
        output occupancy_o
    );

endinterface

// File: rtl/register_stage.sv
// One pipeline slot: loads {valid, data} when enabled; clear drops the valid
// bit only and wins over a load in the same cycle.
module register_stage #(
    parameter int nb_bits = 32
) (
    input  logic               clock_i,
    input  logic               resetb_i,
    input  logic               enable_i,
    input  logic               clear_i,
    input  logic               valid_i,
    input  logic [nb_bits-1:0] data_i,
    output logic               valid_o,
    output logic [nb_bits-1:0] data_o
);

    logic               valid_reg;
    logic [nb_bits-1:0] data_reg;

    always_ff @(posedge clock_i or negedge resetb_i) begin
        if (!resetb_i) begin
            valid_reg <= 1'b0;
        end else if (clear_i) begin
            valid_reg <= 1'b0;
        end else if (enable_i) begin
            valid_reg <= valid_i;
        end
    end

    // Data is frozen on clear so a flushed beat never overwrites the slot.
    always_ff @(posedge clock_i or negedge resetb_i) begin
        if (!resetb_i) begin
            data_reg <= '0;
        end else if (enable_i && !clear_i) begin
            data_reg <= data_i;
        end
    end

    assign valid_o = valid_reg;
    assign data_o  = data_reg;

endmodule

// File: rtl/register_pipe.sv
// Multi-stage valid/ready pipeline register with bubble collapsing,
// back-pressure, synchronous flush and a registered occupancy count.
module register_pipe
    import register_pkg::*;
#(
    parameter int nb_bits   = DEFAULT_NB_BITS,
    parameter int nb_stages = DEFAULT_NB_STAGES
) (
    input  logic          clock_i,
    input  logic          resetb_i,
    register_pipe_if.slave bus
);

    localparam int LAST  = nb_stages - 1;
    localparam int OCC_W = occ_width(nb_stages);

    typedef `REGISTER_STAGE_REC(nb_bits) stage_t;

    stage_t             stage_in  [nb_stages];
    stage_t             stage_out [nb_stages];
    logic [nb_stages-1:0] stage_valid;
    logic [nb_bits-1:0] stage_data [nb_stages];
    logic [nb_stages-1:0] adv;

    logic               accept;
    logic               transfer;
    xfer_e              xfer;
    logic [OCC_W-1:0]   count_reg;
    logic [OCC_W-1:0]   count_next;

    // A stage moves when it is empty or its successor moves, so bubbles fill
    // even while the output is stalled.
    always_comb begin
        adv       = '0;
        adv[LAST] = !stage_valid[LAST] || bus.ready_i;
        for (int k = LAST - 1; k >= 0; k--) begin
            adv[k] = !stage_valid[k] || adv[k+1];
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < nb_stages; gi++) begin : g_stage
            if (gi == 0) begin : g_head
                assign stage_in[gi] = {bus.valid_i, bus.data_i};
            end else begin : g_body
                assign stage_in[gi] = stage_out[gi-1];
            end

            register_stage #(
                .nb_bits (nb_bits)
            ) u_stage (
                .clock_i  (clock_i),
                .resetb_i (resetb_i),
                .enable_i (adv[gi]),
                .clear_i  (bus.flush_i),
                .valid_i  (stage_in[gi].valid),
                .data_i   (stage_in[gi].data),
                .valid_o  (stage_valid[gi]),
                .data_o   (stage_data[gi])
            );

            assign stage_out[gi] = {stage_valid[gi], stage_data[gi]};
        end
    endgenerate

    assign accept   = bus.valid_i && adv[0];
    assign transfer = stage_out[LAST].valid && bus.ready_i;
    assign xfer     = xfer_e'({accept, transfer});

    always_comb begin
        count_next = count_reg;
        if (bus.flush_i) begin
            count_next = '0;
        end else begin
            unique case (xfer)
                XFER_IN:  count_next = count_reg + OCC_W'(1);
                XFER_OUT: count_next = count_reg - OCC_W'(1);
                default:  count_next = count_reg;
            endcase
        end
    end

    always_ff @(posedge clock_i or negedge resetb_i) begin
        if (!resetb_i) begin
            count_reg <= '0;
        end else begin
            count_reg <= count_next;
        end
    end

    assign bus.ready_o     = adv[0];
    assign bus.valid_o     = stage_out[LAST].valid;
    assign bus.data_o      = stage_out[LAST].data;
    assign bus.occupancy_o = count_reg;

endmodule

// File: tb/tb_register_pipe.sv
// Directed bench for register_pipe (32 bits, 3 stages, 10 ns clock).
module tb_register_pipe;

    logic clk;
    logic resetb;
    int   n_checks;
    int   n_fail;

    register_pipe_if #(.nb_bits(32), .nb_stages(3)) bus ();

    register_pipe #(
        .nb_bits   (32),
        .nb_stages (3)
    ) dut (
        .clock_i  (clk),
        .resetb_i (resetb),
        .bus      (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        resetb = 1'b0;
        bus.valid_i = 1'b0; bus.data_i = '0; bus.flush_i = 1'b0; bus.ready_i = 1'b0;
        #2;
        n_checks++; if (bus.valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %0b want 0", bus.valid_o); end
        n_checks++; if (bus.data_o !== 32'h0) begin n_fail++; $display("FAIL reset_data: got %08h want 00000000", bus.data_o); end
        n_checks++; if (bus.occupancy_o !== 2'd0) begin n_fail++; $display("FAIL reset_occ: got %0d want 0", bus.occupancy_o); end
        n_checks++; if (bus.ready_o !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %0b want 1", bus.ready_o); end
        #15;
        resetb = 1'b1;
        for (int c = 0; c < 2; c++) begin
            tick();
            n_checks++; if (bus.valid_o !== 1'b0) begin n_fail++; $display("FAIL idle_valid[%0d]: got %0b want 0", c, bus.valid_o); end
            n_checks++; if (bus.occupancy_o !== 2'd0) begin n_fail++; $display("FAIL idle_occ[%0d]: got %0d want 0", c, bus.occupancy_o); end
            n_checks++; if (bus.ready_o !== 1'b1) begin n_fail++; $display("FAIL idle_ready[%0d]: got %0b want 1", c, bus.ready_o); end
        end
        $display("test_reset done");
    endtask

    task automatic test_streaming();
        logic [31:0] vals [3];
        int          exp_occ [6];
        vals    = '{32'h12345678, 32'hFFF00000, 32'hDEADBEEF};
        exp_occ = '{1, 2, 3, 2, 1, 0};
        bus.ready_i = 1'b1;
        for (int c = 0; c < 6; c++) begin
            bus.valid_i = (c < 3);
            bus.data_i  = (c < 3) ? vals[c] : 32'h0;
            tick();
            if (c >= 2 && c <= 4) begin
                n_checks++; if (bus.valid_o !== 1'b1) begin n_fail++; $display("FAIL stream_valid[%0d]: got %0b want 1", c, bus.valid_o); end
                n_checks++; if (bus.data_o !== vals[c-2]) begin n_fail++; $display("FAIL stream_data[%0d]: got %08h want %08h", c, bus.data_o, vals[c-2]); end
            end else begin
                n_checks++; if (bus.valid_o !== 1'b0) begin n_fail++; $display("FAIL stream_gap[%0d]: got %0b want 0", c, bus.valid_o); end
            end
            n_checks++; if (bus.occupancy_o !== 2'(exp_occ[c])) begin n_fail++; $display("FAIL stream_occ[%0d]: got %0d want %0d", c, bus.occupancy_o, exp_occ[c]); end
        end
        $display("test_streaming done");
    endtask

    task automatic test_back_pressure();
        logic [31:0] b [4];
        b = '{32'hA0000001, 32'hA0000002, 32'hA0000003, 32'hA0000004};
        bus.ready_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            bus.valid_i = 1'b1; bus.data_i = b[i];
            n_checks++; if (bus.ready_o !== 1'b1) begin n_fail++; $display("FAIL bp_accept_ready[%0d]: got %0b want 1", i, bus.ready_o); end
            tick();
        end
        bus.data_i = b[3];
        #1;
        n_checks++; if (bus.ready_o !== 1'b0) begin n_fail++; $display("FAIL bp_full_ready: got %0b want 0", bus.ready_o); end
        n_checks++; if (bus.occupancy_o !== 2'd3) begin n_fail++; $display("FAIL bp_full_occ: got %0d want 3", bus.occupancy_o); end
        tick(); tick();
        n_checks++; if (bus.occupancy_o !== 2'd3) begin n_fail++; $display("FAIL bp_hold_occ: got %0d want 3", bus.occupancy_o); end
        n_checks++; if (bus.data_o !== b[0] || bus.valid_o !== 1'b1) begin n_fail++; $display("FAIL bp_hold_data: got %08h/%0b want %08h/1", bus.data_o, bus.valid_o, b[0]); end
        bus.ready_i = 1'b1;
        #1;
        n_checks++; if (bus.ready_o !== 1'b1) begin n_fail++; $display("FAIL bp_release_ready: got %0b want 1", bus.ready_o); end
        tick();
        bus.valid_i = 1'b0; bus.data_i = '0;
        n_checks++; if (bus.occupancy_o !== 2'd3) begin n_fail++; $display("FAIL bp_swap_occ: got %0d want 3", bus.occupancy_o); end
        for (int i = 1; i < 4; i++) begin
            n_checks++; if (bus.valid_o !== 1'b1 || bus.data_o !== b[i]) begin n_fail++; $display("FAIL bp_drain[%0d]: got %08h/%0b want %08h/1", i, bus.data_o, bus.valid_o, b[i]); end
            tick();
        end
        n_checks++; if (bus.valid_o !== 1'b0 || bus.occupancy_o !== 2'd0) begin n_fail++; $display("FAIL bp_empty: got valid %0b occ %0d want 0/0", bus.valid_o, bus.occupancy_o); end
        $display("test_back_pressure done");
    endtask

    task automatic test_bubble_collapse();
        logic [31:0] a_val;
        logic [31:0] b_val;
        a_val = 32'h0000AAAA;
        b_val = 32'h0000BBBB;
        bus.ready_i = 1'b0;
        bus.valid_i = 1'b1; bus.data_i = a_val; tick();
        bus.valid_i = 1'b0; bus.data_i = '0;    tick();
        bus.valid_i = 1'b1; bus.data_i = b_val; tick();
        bus.valid_i = 1'b0; bus.data_i = '0;
        n_checks++; if (bus.ready_o !== 1'b1 || bus.occupancy_o !== 2'd2) begin n_fail++; $display("FAIL bub_gap: got ready %0b occ %0d want 1/2", bus.ready_o, bus.occupancy_o); end
        tick();
        tick();
        n_checks++; if (bus.occupancy_o !== 2'd2) begin n_fail++; $display("FAIL bub_occ: got %0d want 2", bus.occupancy_o); end
        n_checks++; if (bus.valid_o !== 1'b1 || bus.data_o !== a_val) begin n_fail++; $display("FAIL bub_head: got %08h/%0b want %08h/1", bus.data_o, bus.valid_o, a_val); end
        n_checks++; if (bus.ready_o !== 1'b1) begin n_fail++; $display("FAIL bub_ready: got %0b want 1", bus.ready_o); end
        bus.ready_i = 1'b1;
        tick();
        n_checks++; if (bus.valid_o !== 1'b1 || bus.data_o !== b_val) begin n_fail++; $display("FAIL bub_adjacent: got %08h/%0b want %08h/1", bus.data_o, bus.valid_o, b_val); end
        n_checks++; if (bus.occupancy_o !== 2'd1) begin n_fail++; $display("FAIL bub_occ1: got %0d want 1", bus.occupancy_o); end
        tick();
        n_checks++; if (bus.valid_o !== 1'b0 || bus.occupancy_o !== 2'd0) begin n_fail++; $display("FAIL bub_empty: got valid %0b occ %0d want 0/0", bus.valid_o, bus.occupancy_o); end
        $display("test_bubble_collapse done");
    endtask

    task automatic test_flush();
        logic [31:0] f [3];
        f = '{32'hC0000001, 32'hC0000002, 32'hC0000003};
        bus.ready_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            bus.valid_i = 1'b1; bus.data_i = f[i]; tick();
        end
        bus.flush_i = 1'b1; bus.valid_i = 1'b1; bus.data_i = 32'h87654321; bus.ready_i = 1'b1;
        #1;
        n_checks++; if (bus.ready_o !== 1'b1) begin n_fail++; $display("FAIL flush_ready: got %0b want 1", bus.ready_o); end
        tick();
        bus.flush_i = 1'b0; bus.valid_i = 1'b0; bus.data_i = '0;
        n_checks++; if (bus.valid_o !== 1'b0) begin n_fail++; $display("FAIL flush_valid: got %0b want 0", bus.valid_o); end
        n_checks++; if (bus.occupancy_o !== 2'd0) begin n_fail++; $display("FAIL flush_occ: got %0d want 0", bus.occupancy_o); end
        n_checks++; if (bus.data_o !== f[0]) begin n_fail++; $display("FAIL flush_data_kept: got %08h want %08h", bus.data_o, f[0]); end
        for (int c = 0; c < 4; c++) begin
            tick();
            n_checks++; if (bus.valid_o !== 1'b0 || bus.data_o === 32'h87654321) begin n_fail++; $display("FAIL flush_discard[%0d]: got %08h/%0b want no beat", c, bus.data_o, bus.valid_o); end
        end
        $display("test_flush done");
    endtask

    task automatic test_reset_midstream();
        logic [31:0] m [3];
        m = '{32'hE0000001, 32'hE0000002, 32'hE0000003};
        bus.ready_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            bus.valid_i = 1'b1; bus.data_i = m[i]; tick();
        end
        bus.valid_i = 1'b0; bus.data_i = '0;
        n_checks++; if (bus.occupancy_o !== 2'd3 || bus.data_o !== m[0]) begin n_fail++; $display("FAIL mid_full: got occ %0d data %08h want 3/%08h", bus.occupancy_o, bus.data_o, m[0]); end
        resetb = 1'b0;
        #1;
        n_checks++; if (bus.valid_o !== 1'b0 || bus.data_o !== 32'h0) begin n_fail++; $display("FAIL mid_reset_out: got %08h/%0b want 00000000/0", bus.data_o, bus.valid_o); end
        n_checks++; if (bus.occupancy_o !== 2'd0 || bus.ready_o !== 1'b1) begin n_fail++; $display("FAIL mid_reset_occ: got occ %0d ready %0b want 0/1", bus.occupancy_o, bus.ready_o); end
        #11;
        resetb = 1'b1;
        bus.valid_i = 1'b1; bus.data_i = 32'hDEADBEEF; bus.ready_i = 1'b1;
        tick();
        bus.valid_i = 1'b0; bus.data_i = '0;
        n_checks++; if (bus.valid_o !== 1'b0 || bus.occupancy_o !== 2'd1) begin n_fail++; $display("FAIL mid_restart: got valid %0b occ %0d want 0/1", bus.valid_o, bus.occupancy_o); end
        tick();
        n_checks++; if (bus.valid_o !== 1'b0) begin n_fail++; $display("FAIL mid_early: got %0b want 0", bus.valid_o); end
        tick();
        n_checks++; if (bus.valid_o !== 1'b1 || bus.data_o !== 32'hDEADBEEF) begin n_fail++; $display("FAIL mid_exit: got %08h/%0b want deadbeef/1", bus.data_o, bus.valid_o); end
        tick();
        n_checks++; if (bus.valid_o !== 1'b0 || bus.occupancy_o !== 2'd0) begin n_fail++; $display("FAIL mid_empty: got valid %0b occ %0d want 0/0", bus.valid_o, bus.occupancy_o); end
        $display("test_reset_midstream done");
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_streaming();
        test_back_pressure();
        test_bubble_collapse();
        test_flush();
        test_reset_midstream();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
